// File: rtl/sm_clk_ctrl_pkg.sv
// Shared widths, divider type and per-SM run state for the SM clock sequencer.
package sm_clk_ctrl_pkg;

  localparam int DIV_INT_W  = 16;
  localparam int DIV_FRAC_W = 8;
  // Accumulator must hold int==0 (2**DIV_INT_W) in fixed point, hence one extra bit.
  localparam int ACC_W      = DIV_INT_W + DIV_FRAC_W + 1;

  typedef struct packed {
    logic [DIV_INT_W-1:0]  int_part;
    logic [DIV_FRAC_W-1:0] frac;
  } clkdiv_t;

  typedef enum logic {SM_OFF = 1'b0, SM_RUN = 1'b1} sm_run_t;

  localparam clkdiv_t DIV_RESET = '{int_part: DIV_INT_W'(1), frac: '0};

  // One enabled cycle advances the phase by 1.0 in fixed point.
  localparam logic [ACC_W-1:0] ACC_STEP = ACC_W'(1) << DIV_FRAC_W;

  // Divider as a fixed-point value; int==0 becomes 2**DIV_INT_W via the top bit.
  function automatic logic [ACC_W-1:0] div_fixed(input clkdiv_t d);
    return {(d.int_part == '0), d.int_part, d.frac};
  endfunction

endpackage

// File: rtl/sm_clk_div.sv
// Per-SM fractional clock divider: phase accumulator, divider register and tick flop.
module sm_clk_div
  import sm_clk_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    run,
  input  logic    load,
  input  clkdiv_t div,
  input  logic    phase_clr,
  input  logic    tick_suppress,
  output logic    tick
);

  clkdiv_t          div_q, div_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] acc_inc, dfix;
  logic             tick_q, tick_d;

  // Next phase/tick: a load or phase clear zeroes the phase; otherwise advance while running.
  // Suppression only masks the strobe so the cadence is unaffected.
  always_comb begin
    dfix    = div_fixed(div_q);
    acc_inc = acc_q + ACC_STEP;
    div_d   = div_q;
    acc_d   = acc_q;
    tick_d  = 1'b0;
    if (load) div_d = div;
    if (load || phase_clr) begin
      acc_d = '0;
    end else if (run) begin
      if (acc_inc >= dfix) begin
        tick_d = ~tick_suppress;
        acc_d  = acc_inc - dfix;
      end else begin
        acc_d  = acc_inc;
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= DIV_RESET;
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/sm_clk_ctrl.sv
// Block-level sequencer: enable register, divider-write decode, soft-reset strobes
// and one fractional divider per state machine.
module sm_clk_ctrl
  import sm_clk_ctrl_pkg::*;
#(
  parameter  int NUM_SM = 4,
  localparam int SEL_W  = (NUM_SM > 1) ? $clog2(NUM_SM) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_wr_en,
  input  logic [SEL_W-1:0]      cfg_sm_sel,
  input  logic [DIV_INT_W-1:0]  cfg_div_int,
  input  logic [DIV_FRAC_W-1:0] cfg_div_frac,
  input  logic                  ctrl_en_wr,
  input  logic [NUM_SM-1:0]     ctrl_en,
  input  logic [NUM_SM-1:0]     sm_restart,
  input  logic [NUM_SM-1:0]     clkdiv_restart,
  output logic [NUM_SM-1:0]     sm_tick,
  output logic [NUM_SM-1:0]     sm_rst,
  output logic [NUM_SM-1:0]     sm_enabled
);

  sm_run_t           run_q [NUM_SM];
  sm_run_t           run_d [NUM_SM];
  logic [NUM_SM-1:0] rst_q, rst_d;
  clkdiv_t           cfg_div;

  assign cfg_div = '{int_part: cfg_div_int, frac: cfg_div_frac};

  // Enable write replaces the whole run mask; otherwise each SM holds its state.
  always_comb begin
    for (int i = 0; i < NUM_SM; i++) begin
      run_d[i] = run_q[i];
      if (ctrl_en_wr) run_d[i] = ctrl_en[i] ? SM_RUN : SM_OFF;
    end
    rst_d = sm_restart;
  end

  // Run state and soft-reset strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SM; i++) run_q[i] <= SM_OFF;
      rst_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SM; i++) run_q[i] <= run_d[i];
      rst_q <= rst_d;
    end
  end

  // Enabled mask is a direct view of the run state.
  always_comb begin
    for (int i = 0; i < NUM_SM; i++) sm_enabled[i] = (run_q[i] == SM_RUN);
  end

  assign sm_rst = rst_q;

  for (genvar g = 0; g < NUM_SM; g++) begin : g_div
    sm_clk_div u_div (
      .clk           (clk),
      .rst_n         (rst_n),
      .run           (run_q[g] == SM_RUN),
      .load          (cfg_wr_en && (cfg_sm_sel == SEL_W'(g))),
      .div           (cfg_div),
      .phase_clr     (clkdiv_restart[g]),
      .tick_suppress (sm_restart[g]),
      .tick          (sm_tick[g])
    );
  end

endmodule

// File: tb/tb_sm_clk_ctrl.sv
// Self-checking bench for sm_clk_ctrl: step-count divider model plus directed literals.
module tb_sm_clk_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_wr_en;
  logic [1:0]  cfg_sm_sel;
  logic [15:0] cfg_div_int;
  logic [7:0]  cfg_div_frac;
  logic        ctrl_en_wr;
  logic [3:0]  ctrl_en;
  logic [3:0]  sm_restart;
  logic [3:0]  clkdiv_restart;
  logic [3:0]  sm_tick;
  logic [3:0]  sm_rst;
  logic [3:0]  sm_enabled;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sm_clk_ctrl #(.NUM_SM(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_wr_en      (cfg_wr_en),
    .cfg_sm_sel     (cfg_sm_sel),
    .cfg_div_int    (cfg_div_int),
    .cfg_div_frac   (cfg_div_frac),
    .ctrl_en_wr     (ctrl_en_wr),
    .ctrl_en        (ctrl_en),
    .sm_restart     (sm_restart),
    .clkdiv_restart (clkdiv_restart),
    .sm_tick        (sm_tick),
    .sm_rst         (sm_rst),
    .sm_enabled     (sm_enabled)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, got, exp);
    end
  endtask

  // Model: each SM counts enabled steps n since its last phase zero; with divider D
  // (in 1/256 units) the n-th step ticks iff floor(n*256/D) moves past floor((n-1)*256/D).
  longint    m_n    [4];
  longint    m_dfix [4];
  logic [3:0] m_en   = '0;
  logic [3:0] m_tick = '0;
  logic [3:0] m_rst  = '0;

  initial for (int i = 0; i < 4; i++) begin m_n[i] = 0; m_dfix[i] = 256; end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en = '0; m_tick = '0; m_rst = '0;
      for (int i = 0; i < 4; i++) begin m_n[i] = 0; m_dfix[i] = 256; end
    end else begin
      for (int i = 0; i < 4; i++) begin
        logic t;
        t = 1'b0;
        if (cfg_wr_en && cfg_sm_sel == 2'(i)) begin
          m_dfix[i] = (cfg_div_int == 0 ? 64'd65536 : longint'(cfg_div_int)) * 256
                      + longint'(cfg_div_frac);
          m_n[i] = 0;
        end else if (clkdiv_restart[i]) begin
          m_n[i] = 0;
        end else if (m_en[i]) begin
          m_n[i]++;
          t = ((m_n[i] * 256) / m_dfix[i]) != (((m_n[i] - 1) * 256) / m_dfix[i]);
        end
        if (sm_restart[i]) t = 1'b0;
        m_tick[i] = t;
        m_rst[i]  = sm_restart[i];
      end
      if (ctrl_en_wr) m_en = ctrl_en;
    end
  end

  // Every cycle: outputs must match the model.
  always @(negedge clk) begin
    chk("model_tick", 32'(sm_tick), 32'(m_tick));
    chk("model_rst",  32'(sm_rst),  32'(m_rst));
    chk("model_en",   32'(sm_enabled), 32'(m_en));
  end

  task automatic cyc();
    @(negedge clk); #1;
  endtask

  task automatic idle();
    cfg_wr_en = 0; ctrl_en_wr = 0; sm_restart = '0; clkdiv_restart = '0;
  endtask

  task automatic cfg(input int sm, input int ip, input int fp);
    cfg_wr_en = 1; cfg_sm_sel = 2'(sm); cfg_div_int = 16'(ip); cfg_div_frac = 8'(fp);
  endtask

  initial begin
    rst_n = 0; cfg_sm_sel = '0; cfg_div_int = '0; cfg_div_frac = '0; ctrl_en = '0;
    idle();
    repeat (2) cyc();
    chk("reset_tick", 32'(sm_tick), 0);
    chk("reset_rst",  32'(sm_rst), 0);
    chk("reset_en",   32'(sm_enabled), 0);
    rst_n = 1;
    cyc();

    // 1: default divider, SM0 ticks every cycle from the second edge after the write
    ctrl_en_wr = 1; ctrl_en = 4'b0001; cyc(); idle();
    chk("t1_en", 32'(sm_enabled), 32'h1);
    chk("t1_first0", 32'(sm_tick), 0);
    for (int k = 0; k < 3; k++) begin cyc(); chk("t1_every", 32'(sm_tick), 32'h1); end

    // 2: SM1 div 3.0 then 2.5
    cfg(1, 3, 0); ctrl_en_wr = 1; ctrl_en = 4'b0011; cyc(); idle();
    for (int k = 1; k <= 9; k++) begin
      cyc(); chk("t2_div3", 32'(sm_tick[1]), (k % 3 == 0) ? 1 : 0);
    end
    cfg(1, 2, 128); cyc(); idle();
    for (int k = 1; k <= 10; k++) begin
      cyc(); chk("t2_div2p5", 32'(sm_tick[1]), (k == 3 || k == 5 || k == 8 || k == 10) ? 1 : 0);
    end

    // 4: SM0/SM1 at 4.0 with offset phases, then aligned by clkdiv_restart
    cfg(0, 4, 0); cyc(); idle(); cyc(); cyc();
    cfg(1, 4, 0); cyc(); idle(); cyc();
    clkdiv_restart = 4'b0011; cyc(); idle();
    for (int k = 1; k <= 8; k++) begin
      cyc(); chk("t4_aligned", 32'(sm_tick[1:0]), (k % 4 == 0) ? 32'h3 : 32'h0);
    end

    // 5: soft reset of SM3 while running at 1.0
    ctrl_en_wr = 1; ctrl_en = 4'b1011; cyc(); idle(); cyc(); cyc();
    chk("t5_pre", 32'(sm_tick[3]), 1);
    sm_restart = 4'b1000; cyc(); idle();
    chk("t5_rst", 32'(sm_rst), 32'h8);
    chk("t5_sup", 32'(sm_tick[3]), 0);
    cyc();
    chk("t5_rst_off", 32'(sm_rst), 0);
    chk("t5_cadence", 32'(sm_tick[3]), 1);

    // 6: disable SM1 at acc=512 (D=4.0), re-enable 10 cycles later
    clkdiv_restart = 4'b0010; cyc(); idle(); cyc();
    ctrl_en_wr = 1; ctrl_en = 4'b1001; cyc(); idle();
    chk("t6_off", 32'(sm_enabled), 32'h9);
    repeat (10) cyc();
    ctrl_en_wr = 1; ctrl_en = 4'b1011; cyc(); idle();
    chk("t6_re0", 32'(sm_tick[1]), 0);
    cyc(); chk("t6_re1", 32'(sm_tick[1]), 0);
    cyc(); chk("t6_re2", 32'(sm_tick[1]), 1);

    // async reset with an sm_rst in flight
    sm_restart = 4'b1000; cyc(); idle();
    chk("t6_inflight", 32'(sm_rst), 32'h8);
    rst_n = 0; #1;
    chk("t6_async_tick", 32'(sm_tick), 0);
    chk("t6_async_rst",  32'(sm_rst), 0);
    chk("t6_async_en",   32'(sm_enabled), 0);
    cyc(); rst_n = 1; cyc();

    // 3: int=0 on SM2 -> first tick after exactly 65536 enabled cycles
    cfg(2, 0, 0); ctrl_en_wr = 1; ctrl_en = 4'b0100; cyc(); idle();
    repeat (65535) cyc();
    chk("t3_before", 32'(sm_tick[2]), 0);
    cyc();
    chk("t3_tick", 32'(sm_tick[2]), 1);
    cyc();
    chk("t3_after", 32'(sm_tick[2]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
